parity_frame_chk: RTL and testbench
===================================

# parity_frame_chk

Streaming, parametrised parity generator/checker that folds parity across multi-word frames rather than a single byte. Each input word is masked by a selectable bit group (upper half, even-index bits, odd-index bits, all bits), and the selected bits are XOR-accumulated until the frame's last word. The block then emits one registered parity result, an error flag from comparison with a received parity bit and, optionally, the frame length. It sits on a valid/ready stream between a data source and a checker/status consumer.

## Interface
- W, 8, data word width; must be even and ≥2
- LW, 8, width of frame word counter / out_len

- clk  in  1  clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  input word valid
- in_ready  out  1  block accepts word this cycle
- in_data  in  W  data word
- in_last  in  1  word is last of frame
- chk  in  2  bit-group select: 00 upper half [W-1:W/2], 01 even indices (0,2,..), 10 odd indices (1,3,..), 11 all bits
- even  in  1  polarity: 0 → result = XOR of selected bits; 1 → inverted XOR
- par_in  in  1  received parity bit, sampled with the last word
- out_valid  out  1  result valid
- out_ready  in  1  consumer takes result
- out_par  out  1  computed frame parity
- out_err  out  1  1 when par_in ≠ out_par
- out_len  out  LW  accepted words in frame (see Configuration)

## Operation
- Input accept: in_valid & in_ready. Output take: out_valid & out_ready.
- in_ready = ~out_valid | out_ready (single result slot; combinational).
- States: IDLE (no word of current frame accepted), BUSY (≥1 word accepted, last not yet seen).
- IDLE, accept with in_last=0: latch chk/even into mode regs, acc ← ^(in_data & mask(chk)), cnt ← 1, → BUSY.
- IDLE, accept with in_last=1 (one-word frame): result from live chk/even, stay IDLE.
- BUSY, accept: mask and polarity come from latched mode; live chk/even are ignored until the next frame starts. in_last=0: acc ^= word parity, cnt+1. in_last=1: produce result, → IDLE.
- Result on last-word accept: p = acc_prev ^ ^(in_data & mask); out_par ← p ^ even_eff; out_err ← par_in ^ (p ^ even_eff); out_len ← cnt_prev+1; out_valid ← 1. acc_prev = 0 and cnt_prev = 0 for one-word frames.
- out_valid clears on take unless a new result is written in the same cycle; a new result has priority.
- cnt saturates at 2^LW−1; parity accumulation continues past saturation.
- Without in_valid, no state changes; out_* regs hold while out_valid & ~out_ready.

## Timing
- Reset: out_valid=0, out_par=0, out_err=0, out_len=0, state IDLE, acc=0, cnt=0, mode regs=0. in_ready=1 during and after reset.
- Reset mid-frame discards the partial frame and any pending result. The first accept after reset starts a new frame.
- Latency: out_valid rises the cycle after the last-word accept.
- Throughput: one word per cycle. Back-to-back frames are sustained at full rate when out_ready=1.
- Simultaneous take and last-word accept: the old result leaves, the new result loads, and out_valid stays 1.
- out_valid=1 & out_ready=0: in_ready=0, and in_data/in_last are held by the source (no accept).

## Configuration
- PARITY_FRAME_LEN_EN defined: cnt register and out_len are implemented as above.
- Not defined: no counter logic; out_len tied to 0. The port list is unchanged.

## Test plan
- W=8, one word 0xF0, chk=00, even=0, par_in=0, last=1 → next cycle out_valid=1, out_par=0, out_err=0, out_len=1.
- One word 0x01, chk=11: even=0, par_in=1 → out_par=1, out_err=0. even=1, par_in=1 → out_par=0, out_err=1.
- Frame 0x01,0x02,0x04 (last on third), chk=11, even=0, par_in=0 → out_par=1, out_err=1, out_len=3, and out_valid appears exactly once.
- Mode change mid-frame: word1 0x01 chk=01, word2 0x01 chk=10 last → even-index mask used for both words → out_par=0, out_len=2.
- Backpressure: hold out_ready=0 after a result → in_ready=0, outputs stable for 5 cycles. Raise out_ready with a pending one-word frame 0x80, chk=10 → out_valid stays 1 and the new out_par=1 next cycle.
- Reset asserted after 2 words of a frame, then frame 0x03 chk=11 last → out_par=0, out_len=1. Nothing is emitted for the aborted frame.

Source files
------------

// File: rtl/parity_frame_chk.sv
// parity_frame_chk
//   Streaming frame parity generator/checker. Each accepted word is masked by
//   a selectable bit group and its parity is XOR-folded across the frame.
//   When the last word of the frame is accepted, one registered result is
//   produced: the frame parity, a mismatch flag against par_in, and optionally
//   the frame length.
//
//   Optional feature: define PARITY_FRAME_LEN_EN to build the word counter and
//   drive out_len. Without it, out_len is tied to 0 and no counter is built.
//
// Ports
//   clk, rst          clock, synchronous active-high reset
//   in_valid/in_ready input word handshake
//   in_data, in_last  data word, last-word-of-frame marker
//   chk               group select: 00 upper half, 01 even idx, 10 odd idx, 11 all
//   even              1 inverts the XOR result
//   par_in            received parity, sampled with the last word
//   out_valid/out_ready result handshake (single result slot)
//   out_par, out_err  frame parity, par_in mismatch
//   out_len           accepted words in frame (saturating)
module parity_frame_chk #(
  parameter int W  = 8,
  parameter int LW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [W-1:0]  in_data,
  input  logic          in_last,
  input  logic [1:0]    chk,
  input  logic          even,
  input  logic          par_in,
  output logic          out_valid,
  input  logic          out_ready,
  output logic          out_par,
  output logic          out_err,
  output logic [LW-1:0] out_len
);

  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

  state_t     state_q, state_d;
  logic [1:0] mode_chk_q;
  logic       mode_even_q;
  logic       acc_q;

  logic       accept, take;
  logic [1:0] chk_eff;
  logic       even_eff;
  logic       word_par, frame_par;

  function automatic logic [W-1:0] grp_mask(input logic [1:0] c);
    logic [W-1:0] m;
    m = '0;
    for (int i = 0; i < W; i++) begin
      case (c)
        2'b00:   m[i] = (i >= W/2);
        2'b01:   m[i] = ((i % 2) == 0);
        2'b10:   m[i] = ((i % 2) == 1);
        default: m[i] = 1'b1;
      endcase
    end
    return m;
  endfunction

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next state
  always_comb begin
    state_d = state_q;
    if (accept) begin
      case (state_q)
        IDLE:    if (!in_last) state_d = BUSY;
        BUSY:    if (in_last)  state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  // Handshake and datapath selects. The first word of a frame uses the live
  // mode inputs; later words use the mode latched on that first word.
  always_comb begin
    in_ready  = ~out_valid | out_ready;
    accept    = in_valid & in_ready;
    take      = out_valid & out_ready;
    chk_eff   = (state_q == IDLE) ? chk  : mode_chk_q;
    even_eff  = (state_q == IDLE) ? even : mode_even_q;
    word_par  = ^(in_data & grp_mask(chk_eff));
    // acc_q is held at 0 whenever no frame is open, so no IDLE select needed.
    frame_par = acc_q ^ word_par;
  end

  // Mode latch, accumulator and result slot. A new result overrides a take
  // in the same cycle, so out_valid stays high across back-to-back frames.
  always_ff @(posedge clk) begin
    if (rst) begin
      mode_chk_q  <= '0;
      mode_even_q <= 1'b0;
      acc_q       <= 1'b0;
      out_valid   <= 1'b0;
      out_par     <= 1'b0;
      out_err     <= 1'b0;
    end else begin
      if (take) out_valid <= 1'b0;
      if (accept) begin
        if (in_last) begin
          out_valid <= 1'b1;
          out_par   <= frame_par ^ even_eff;
          out_err   <= par_in ^ frame_par ^ even_eff;
          acc_q     <= 1'b0;
        end else begin
          acc_q <= frame_par;
          if (state_q == IDLE) begin
            mode_chk_q  <= chk;
            mode_even_q <= even;
          end
        end
      end
    end
  end

`ifdef PARITY_FRAME_LEN_EN
  // cnt_q counts words already accepted in the open frame (0 when idle).
  logic [LW-1:0] cnt_q, len_nxt;

  assign len_nxt = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q   <= '0;
      out_len <= '0;
    end else if (accept) begin
      if (in_last) begin
        out_len <= len_nxt;
        cnt_q   <= '0;
      end else begin
        cnt_q <= len_nxt;
      end
    end
  end
`else
  assign out_len = '0;
`endif

endmodule

// File: tb/tb_parity_frame_chk.sv
module tb_parity_frame_chk;
  localparam int W  = 8;
  localparam int LW = 8;
`ifdef PARITY_FRAME_LEN_EN
  localparam bit LEN_EN = 1'b1;
`else
  localparam bit LEN_EN = 1'b0;
`endif
  localparam int LEN_MAX = (1 << LW) - 1;

  logic          clk = 1'b0;
  logic          rst, in_valid, in_ready, in_last, even, par_in;
  logic          out_valid, out_ready, out_par, out_err;
  logic [W-1:0]  in_data;
  logic [1:0]    chk;
  logic [LW-1:0] out_len;

  int total = 0;
  int bad   = 0;
  bit run   = 1'b0;

  always #5 clk = ~clk;

  parity_frame_chk #(.W(W), .LW(LW)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_last(in_last), .chk(chk), .even(even),
    .par_in(par_in), .out_valid(out_valid), .out_ready(out_ready),
    .out_par(out_par), .out_err(out_err), .out_len(out_len)
  );

  // Reference model: keeps the words of the open frame and recomputes the
  // frame parity from scratch by counting selected set bits.
  bit         m_valid = 1'b0, m_par = 1'b0, m_err = 1'b0;
  int         m_len = 0;
  int         fq[$];
  logic [1:0] f_chk;
  bit         f_even;

  function automatic bit grp_par(input int w, input logic [1:0] c);
    int n = 0;
    bit sel;
    for (int i = 0; i < W; i++) begin
      case (c)
        2'b00:   sel = (i >= W/2);
        2'b01:   sel = (i % 2 == 0);
        2'b10:   sel = (i % 2 == 1);
        default: sel = 1'b1;
      endcase
      if (sel && w[i]) n++;
    end
    return n[0];
  endfunction

  task automatic model_step();
    bit acc;
    bit p;
    if (rst) begin
      m_valid = 0; m_par = 0; m_err = 0; m_len = 0;
      fq.delete();
    end else begin
      acc = in_valid && (!m_valid || out_ready);
      if (m_valid && out_ready) m_valid = 0;
      if (acc) begin
        if (fq.size() == 0) begin
          f_chk  = chk;
          f_even = even;
        end
        fq.push_back(int'(in_data));
        if (in_last) begin
          p = 0;
          foreach (fq[k]) p ^= grp_par(fq[k], f_chk);
          m_par   = p ^ f_even;
          m_err   = par_in ^ m_par;
          m_len   = LEN_EN ? ((fq.size() > LEN_MAX) ? LEN_MAX : fq.size()) : 0;
          m_valid = 1;
          fq.delete();
        end
      end
    end
  endtask

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Per-cycle comparison against the model
  always @(negedge clk) begin
    if (run) begin
      check("cyc_out_valid", 32'(out_valid), 32'(m_valid));
      check("cyc_in_ready", 32'(in_ready), 32'(!m_valid || out_ready));
      if (m_valid) begin
        check("cyc_out_par", 32'(out_par), 32'(m_par));
        check("cyc_out_err", 32'(out_err), 32'(m_err));
        check("cyc_out_len", 32'(out_len), 32'(m_len));
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic send(input logic [7:0] d, input bit l, input logic [1:0] c,
                      input bit e, input bit p);
    in_valid = 1; in_data = d; in_last = l; chk = c; even = e; par_in = p;
    cyc();
    in_valid = 0; in_last = 0;
  endtask

  initial begin
    rst = 1; in_valid = 0; in_data = '0; in_last = 0; chk = '0; even = 0;
    par_in = 0; out_ready = 1;
    cyc(); cyc();
    run = 1;
    check("rst_out_valid", 32'(out_valid), 0);
    check("rst_out_par", 32'(out_par), 0);
    check("rst_out_err", 32'(out_err), 0);
    check("rst_out_len", 32'(out_len), 0);
    check("rst_in_ready", 32'(in_ready), 1);
    rst = 0;
    cyc();

    // one word, upper half of 0xF0
    send(8'hF0, 1, 2'b00, 0, 0);
    check("t1_valid", 32'(out_valid), 1);
    check("t1_par", 32'(out_par), 0);
    check("t1_err", 32'(out_err), 0);
    check("t1_len", 32'(out_len), LEN_EN ? 1 : 0);

    // polarity, back to back
    send(8'h01, 1, 2'b11, 0, 1);
    check("t2a_par", 32'(out_par), 1);
    check("t2a_err", 32'(out_err), 0);
    send(8'h01, 1, 2'b11, 1, 1);
    check("t2b_par", 32'(out_par), 0);
    check("t2b_err", 32'(out_err), 1);
    cyc();

    // three-word frame
    send(8'h01, 0, 2'b11, 0, 0);
    check("t3_no_early", 32'(out_valid), 0);
    send(8'h02, 0, 2'b11, 0, 0);
    send(8'h04, 1, 2'b11, 0, 0);
    check("t3_par", 32'(out_par), 1);
    check("t3_err", 32'(out_err), 1);
    check("t3_len", 32'(out_len), LEN_EN ? 3 : 0);
    cyc();
    check("t3_once", 32'(out_valid), 0);

    // mode latched on first word
    send(8'h01, 0, 2'b01, 0, 0);
    send(8'h01, 1, 2'b10, 0, 0);
    check("t4_par", 32'(out_par), 0);
    check("t4_len", 32'(out_len), LEN_EN ? 2 : 0);
    cyc();

    // backpressure
    out_ready = 0;
    send(8'h01, 1, 2'b11, 0, 0);
    for (int i = 0; i < 5; i++) begin
      cyc();
      check("t5_hold_valid", 32'(out_valid), 1);
      check("t5_hold_ready", 32'(in_ready), 0);
      check("t5_hold_par", 32'(out_par), 1);
      check("t5_hold_err", 32'(out_err), 1);
    end
    in_valid = 1; in_data = 8'h80; in_last = 1; chk = 2'b10; even = 0; par_in = 0;
    out_ready = 1;
    #1 check("t5_release_ready", 32'(in_ready), 1);
    cyc();
    in_valid = 0; in_last = 0;
    check("t5_new_valid", 32'(out_valid), 1);
    check("t5_new_par", 32'(out_par), 1);
    cyc();

    // reset mid-frame
    send(8'h55, 0, 2'b01, 1, 0);
    send(8'h0F, 0, 2'b01, 1, 0);
    rst = 1;
    cyc();
    rst = 0;
    check("t6_rst_valid", 32'(out_valid), 0);
    send(8'h03, 1, 2'b11, 0, 0);
    check("t6_par", 32'(out_par), 0);
    check("t6_len", 32'(out_len), LEN_EN ? 1 : 0);
    cyc();
    check("t6_once", 32'(out_valid), 0);

    // randomized traffic; a blocked word is held until accepted
    for (int n = 0; n < 1500; n++) begin
      if (!(in_valid && m_valid && !out_ready)) begin
        in_valid = ($urandom_range(0, 3) != 0);
        in_data  = W'($urandom);
        in_last  = ($urandom_range(0, 3) == 0);
        chk      = 2'($urandom);
        even     = 1'($urandom);
        par_in   = 1'($urandom);
      end
      out_ready = ($urandom_range(0, 2) != 0);
      rst       = ($urandom_range(0, 199) == 0);
      cyc();
    end
    rst = 0; in_valid = 0; in_last = 0; out_ready = 1;
    cyc();

    // long frame past counter saturation
    for (int n = 0; n < 300; n++)
      send(8'($urandom), (n == 299), 2'b11, 0, 0);
    check("t7_len_sat", 32'(out_len), LEN_EN ? LEN_MAX : 0);
    cyc(); cyc();

    run = 0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
